// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- round sequencer for an iterative AES encryption datapath.
//
// Purpose:
//   Accepts a plaintext block and fetches round keys 0..NUM_ROUNDS from the key expander,
//   one handshake per key. For each key it pulses one datapath strobe: the initial
//   AddRoundKey, then one full round per key, with mix_columns dropped in the last round.
//   The ciphertext is then offered on a valid/ready handshake. The 128-bit state register
//   and the round logic live in the datapath and are driven by these strobes.
//
// Parameters:
//   NUM_ROUNDS  number of full rounds, 1..14 (10/12/14 for AES-128/192/256)
//   RW          round index width, 2**RW must exceed NUM_ROUNDS
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    plaintext block present on the datapath input
//   in_ready    controller idle and able to accept a block
//   abort       synchronous flush of the operation in flight
//   load_state  datapath captures the plaintext this cycle
//   key_req     request round key key_round from the key expander
//   key_round   index of the requested round key
//   key_valid   key expander presents round key key_round this cycle
//   ark_only    datapath does state ^= key (initial AddRoundKey)
//   round_en    datapath does one full round with the presented key
//   mix_en      qualifies round_en: 1 = include mix_columns, 0 = final round
//   out_valid   ciphertext valid in the datapath state register
//   out_ready   consumer accepts the ciphertext
//   busy        controller is not idle
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned RW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          abort,
  output logic          load_state,
  output logic          key_req,
  output logic [RW-1:0] key_round,
  input  logic          key_valid,
  output logic          ark_only,
  output logic          round_en,
  output logic          mix_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [RW-1:0] LastRound = RW'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    StIdle,
    StKey0,
    StRound,
    StOut
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_idx_q, round_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    in_ready    = 1'b0;
    load_state  = 1'b0;
    key_req     = 1'b0;
    ark_only    = 1'b0;
    round_en    = 1'b0;
    mix_en      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        in_ready = !rst;
        // abort in idle blocks acceptance even though in_ready stays high
        if (in_valid && !abort && !rst) begin
          load_state  = 1'b1;
          round_idx_d = '0;
          state_d     = StKey0;
        end
      end

      StKey0: begin
        if (abort) begin
          round_idx_d = '0;
          state_d     = StIdle;
        end else begin
          key_req = 1'b1;
          if (key_valid) begin
            ark_only    = 1'b1;
            round_idx_d = RW'(1);
            state_d     = StRound;
          end
        end
      end

      StRound: begin
        if (abort) begin
          round_idx_d = '0;
          state_d     = StIdle;
        end else begin
          key_req = 1'b1;
          if (key_valid) begin
            round_en = 1'b1;
            mix_en   = (round_idx_q != LastRound);
            // index parks on the last round so it never exceeds NUM_ROUNDS
            if (round_idx_q == LastRound) begin
              state_d = StOut;
            end else begin
              round_idx_d = round_idx_q + RW'(1);
            end
          end
        end
      end

      StOut: begin
        out_valid = 1'b1;
        if (abort) begin
          round_idx_d = '0;
          state_d     = StIdle;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        round_idx_d = '0;
        state_d     = StIdle;
      end
    endcase
  end

  assign key_round = round_idx_q;

  // Datapath strobes must never overlap, and key consumers need a valid key.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({load_state, ark_only, round_en}));

  a_key_qualified: assert property (@(posedge clk) disable iff (rst)
    (ark_only || round_en) |-> (key_valid && key_req));

  a_mix_qualified: assert property (@(posedge clk) disable iff (rst)
    mix_en |-> round_en);

  a_idx_bound: assert property (@(posedge clk) disable iff (rst)
    round_idx_q <= LastRound);

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !abort) |=> out_valid);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: one instance with 10 rounds for scripted timing tables,
// one with 14 rounds for randomized stalls, each driving a behavioural AES datapath.
module tb_aes_round_ctrl;

  localparam int NR10 = 10;
  localparam int NR14 = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 10-round instance signals
  logic iv10, ir10, ab10, ld10, kq10, kv10, ark10, ren10, mix10, ov10, ordy10, bz10;
  logic [3:0] kr10;
  // 14-round instance signals
  logic iv14, ir14, ab14, ld14, kq14, kv14, ark14, ren14, mix14, ov14, ordy14, bz14;
  logic [3:0] kr14;

  aes_round_ctrl #(.NUM_ROUNDS(NR10), .RW(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .abort(ab10),
    .load_state(ld10), .key_req(kq10), .key_round(kr10), .key_valid(kv10),
    .ark_only(ark10), .round_en(ren10), .mix_en(mix10), .out_valid(ov10),
    .out_ready(ordy10), .busy(bz10)
  );

  aes_round_ctrl #(.NUM_ROUNDS(NR14), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .abort(ab14),
    .load_state(ld14), .key_req(kq14), .key_round(kr14), .key_valid(kv14),
    .ark_only(ark14), .round_en(ren14), .mix_en(mix14), .out_valid(ov14),
    .out_ready(ordy14), .busy(bz14)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- AES reference ----------------
  logic [7:0]   sbox [256];
  logic [127:0] ks   [15];
  logic [127:0] rk10 [15];
  logic [127:0] rk14 [15];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        a[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        a[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        a[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        a[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end else begin
      a = b;
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r ^ k;
  endfunction

  // Whole-block encryption with the schedule currently in ks.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ ks[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, ks[r], r != nr);
    return s;
  endfunction

  // ---------------- datapath models driven by the strobes ----------------
  logic [127:0] pt10, dp10, pt14, dp14;
  int kcnt14;

  always @(posedge clk) begin
    if (ld10)       dp10 <= pt10;
    else if (ark10) dp10 <= dp10 ^ rk10[kr10];
    else if (ren10) dp10 <= aes_round(dp10, rk10[kr10], mix10);
  end

  always @(posedge clk) begin
    if (ld14)       dp14 <= pt14;
    else if (ark14) dp14 <= dp14 ^ rk14[kr14];
    else if (ren14) dp14 <= aes_round(dp14, rk14[kr14], mix14);
    if (ld14)                kcnt14 <= 0;
    else if (kq14 && kv14)   kcnt14 <= kcnt14 + 1;
  end

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("inv10", 128'(($countones({ld10, ark10, ren10}) <= 1)
                          && (!(ark10 || ren10) || (kv10 && kq10))
                          && (!mix10 || ren10) && (kr10 <= 4'(NR10)) && !(ov10 && ir10)),
            128'd1);
      check("inv14", 128'(($countones({ld14, ark14, ren14}) <= 1)
                          && (!(ark14 || ren14) || (kv14 && kq14))
                          && (!mix14 || ren14) && (kr14 <= 4'(NR14)) && !(ov14 && ir14)),
            128'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- vector tables ----------------
  // exp = {in_ready, load_state, key_req, key_round[3:0], ark_only, round_en, mix_en,
  //        out_valid, busy}; key_round is zeroed whenever key_req is low.
  typedef struct {
    int         cyc;
    logic       iv, kv, ordy;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[$];

  localparam logic [11:0] ExpIdle = 12'h800;
  localparam logic [11:0] ExpBusyOnly = 12'h001;

  function automatic logic [11:0] pack10();
    return {ir10, ld10, kq10, (kq10 ? kr10 : 4'h0), ark10, ren10, mix10, ov10, bz10};
  endfunction

  function automatic logic [11:0] pack14();
    return {ir14, ld14, kq14, (kq14 ? kr14 : 4'h0), ark14, ren14, mix14, ov14, bz14};
  endfunction

  // Expected timeline of one block from the latency rules: key k arrives at cycle 1+k,
  // delayed by sl cycles from key sk on; out_valid from NR+2+sl for orl+1 cycles.
  task automatic build(input int sk, input int sl, input int orl, input bit hold,
                       input int first, input int last);
    int ov0, ov1, stop, k;
    vec_t v;
    logic ir, ld, kq, ak, rn, mx, ov, bz;
    logic [3:0] kr;
    ov0 = NR10 + 2 + sl;
    ov1 = ov0 + orl;
    stop = (last < 0) ? ov1 + 1 : last;
    tbl.delete();
    for (int c = first; c <= stop; c++) begin
      v.cyc  = c;
      v.iv   = (c == 0) || (hold && c >= ov0);
      v.kv   = !(c >= 1 + sk && c < 1 + sk + sl);
      v.ordy = (orl == 0) ? 1'b1 : (c >= ov1);
      ir = 0; ld = 0; kq = 0; ak = 0; rn = 0; mx = 0; ov = 0; bz = 0; kr = 4'h0;
      if (c == 0) begin
        ir = 1; ld = 1;
      end else if (c < ov0) begin
        bz = 1; kq = 1;
        if (c < 1 + sk)           k = c - 1;
        else if (c < 1 + sk + sl) k = sk;
        else                      k = c - 1 - sl;
        kr = 4'(k);
        ak = v.kv && (k == 0);
        rn = v.kv && (k > 0);
        mx = rn && (k != NR10);
      end else if (c <= ov1) begin
        bz = 1; ov = 1;
      end else begin
        ir = 1; ld = v.iv;
      end
      v.exp = {ir, ld, kq, kr, ak, rn, mx, ov, bz};
      tbl.push_back(v);
    end
  endtask

  task automatic apply_rows(input string name);
    foreach (tbl[i]) begin
      @(negedge clk);
      iv10 = tbl[i].iv; kv10 = tbl[i].kv; ordy10 = tbl[i].ordy; ab10 = 1'b0;
      #1;
      check($sformatf("%s_c%0d", name, tbl[i].cyc), 128'(pack10()), 128'(tbl[i].exp));
    end
  endtask

  task automatic apply_one(input string name, input logic iv, input logic kv, input logic ordy,
                           input logic ab, input logic [11:0] exp);
    @(negedge clk);
    iv10 = iv; kv10 = kv; ordy10 = ordy; ab10 = ab;
    #1;
    check(name, 128'(pack10()), 128'(exp));
  endtask

  localparam logic [127:0] Ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [255:0] key;
    logic [127:0] pt, expct;
    int budget;
    bit accepted, done;

    rst = 1'b1;
    iv10 = 0; kv10 = 0; ordy10 = 0; ab10 = 0;
    iv14 = 0; kv14 = 0; ordy14 = 0; ab14 = 0;
    pt10 = 128'h00112233445566778899aabbccddeeff;
    pt14 = '0;
    build_sbox();
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR10);
    rk10 = ks;
    rk14 = ks;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("reset10", 128'(pack10()), 128'h0);
    check("reset14", 128'(pack14()), 128'h0);
    check("reset_idx10", 128'(kr10), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle10", 128'(pack10()), 128'(ExpIdle));
    check("idle14", 128'(pack14()), 128'(ExpIdle));

    // T1 back-to-back keys
    build(99, 0, 0, 1'b0, 0, -1);
    apply_rows("t1");
    check("t1_ct", dp10, Ct1);

    // T2 key stall during round 5
    build(5, 3, 0, 1'b0, 0, -1);
    apply_rows("t2");
    check("t2_ct", dp10, Ct1);

    // T3 output backpressure with the next block waiting
    build(99, 0, 4, 1'b1, 0, -1);
    apply_rows("t3");
    check("t3_ct", dp10, Ct1);
    build(99, 0, 0, 1'b0, 1, -1);
    apply_rows("t3b");
    check("t3b_ct", dp10, Ct1);

    // T4 abort in round 7, then abort while idle, then a clean block
    build(99, 0, 0, 1'b0, 0, 7);
    apply_rows("t4");
    apply_one("t4_abort_cycle", 1'b0, 1'b1, 1'b1, 1'b1, ExpBusyOnly);
    apply_one("t4_abort_idle", 1'b1, 1'b1, 1'b1, 1'b1, ExpIdle);
    apply_one("t4_still_idle", 1'b0, 1'b1, 1'b1, 1'b0, ExpIdle);
    build(99, 0, 0, 1'b0, 0, -1);
    apply_rows("t4b");
    check("t4b_ct", dp10, Ct1);

    // T5 reset in round 3
    build(99, 0, 0, 1'b0, 0, 3);
    apply_rows("t5");
    @(negedge clk);
    rst = 1'b1; iv10 = 0; kv10 = 1;
    #1;
    check("t5_rst_in_ready", 128'(ir10), 128'h0);
    @(negedge clk);
    #1;
    check("t5_reset_values", 128'(pack10()), 128'h0);
    check("t5_reset_idx", 128'(kr10), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_idle", 128'(pack10()), 128'(ExpIdle));
    build(99, 0, 0, 1'b0, 0, -1);
    apply_rows("t5b");
    check("t5b_ct", dp10, Ct1);

    // T6 AES-256 with random key/output stalls
    for (int b = 0; b < 100; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, 8, NR14);
      rk14  = ks;
      expct = aes_ref(pt, NR14);
      pt14  = pt;
      accepted = 0;
      done = 0;
      budget = 0;
      while (!done && budget < 1000) begin
        @(negedge clk);
        iv14   = !accepted && ($urandom_range(0, 3) != 0);
        kv14   = ($urandom_range(0, 2) != 0);
        ordy14 = ($urandom_range(0, 1) == 1);
        #1;
        if (ld14) accepted = 1;
        if (ov14 && ordy14) begin
          done = 1;
          check($sformatf("t6_ct_b%0d", b), dp14, expct);
          check($sformatf("t6_keys_b%0d", b), 128'(kcnt14), 128'(NR14 + 1));
        end
        budget++;
      end
      if (!done) begin
        check($sformatf("t6_timeout_b%0d", b), 128'(done), 128'h1);
        b = 100;
      end
    end
    @(negedge clk);
    iv14 = 0; kv14 = 0; ordy14 = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
